boid_frame_renderer: RTL and testbench

Parametrised successor to the wrapper-level boid display update loop. It holds the positions of all boids in an internal register array written by the CPU, which replaces the per-boid position units and the tristate read bus. On each frame-start pulse it issues a one-cycle clear to the boid display RAM, then walks every boid and writes a square sprite of pixels at its position. It sits between the CPU register taps and the resettable boid display RAM.

---
 rtl/boid_frame_renderer_if.sv | 31 +++
 rtl/boid_frame_renderer.sv | 180 ++++++++++++++++++
 tb/tb_boid_frame_renderer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boid_frame_renderer_if.sv
// Bus between the CPU register taps and the renderer, and between the renderer and
// the boid display RAM. The driver of the taps uses the master modport; the renderer
// uses the slave modport.
interface boid_frame_renderer_if #(
    parameter int IDX_W  = 6,
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = 19
);
    logic              cpu_we;
    logic [IDX_W-1:0]  cpu_idx;
    logic [X_W-1:0]    cpu_x;
    logic [Y_W-1:0]    cpu_y;
    logic              frame_start;
    logic              busy;
    logic              clear;
    logic              pix_we;
    logic [ADDR_W-1:0] pix_addr;
    logic              done;
    logic [7:0]        overrun_cnt;

    modport master (
        output cpu_we, cpu_idx, cpu_x, cpu_y, frame_start,
        input  busy, clear, pix_we, pix_addr, done, overrun_cnt
    );

    modport slave (
        input  cpu_we, cpu_idx, cpu_x, cpu_y, frame_start,
        output busy, clear, pix_we, pix_addr, done, overrun_cnt
    );
endinterface

// File: rtl/boid_frame_renderer.sv
// boid_frame_renderer: keeps every boid position in a register array written by the
// CPU and, on each frame_start, clears the display RAM for one cycle and then draws a
// SPRITE x SPRITE square per boid, one pixel slot per cycle.
// Optional feature: define BOID_VALID_MASK_EN to draw only boids written since reset.
module boid_frame_renderer #(
    parameter int NUM_BOIDS = 64,
    parameter int IDX_W     = $clog2(NUM_BOIDS),
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int ADDR_W    = 19,
    parameter int SPRITE    = 1
) (
    input logic                  clock,
    input logic                  reset,
    boid_frame_renderer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

    localparam logic [1:0]        LP_SPR_MAX = 2'(SPRITE - 1);
    localparam logic [IDX_W-1:0]  LP_LAST_B  = IDX_W'(NUM_BOIDS - 1);
    localparam logic [X_W+1:0]    LP_SW      = (X_W + 2)'(SCREEN_W);
    localparam logic [Y_W+1:0]    LP_SH      = (Y_W + 2)'(SCREEN_H);
    localparam logic [ADDR_W-1:0] LP_SW_A    = ADDR_W'(SCREEN_W);

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_b, w_b_nxt;
    logic [1:0]        r_dx, r_dy, w_dx_nxt, w_dy_nxt;
    logic              w_slot_nxt;
    logic [X_W-1:0]    r_pos_x [NUM_BOIDS];
    logic [Y_W-1:0]    r_pos_y [NUM_BOIDS];
    logic [X_W-1:0]    r_snap_x, w_cur_x;
    logic [Y_W-1:0]    r_snap_y, w_cur_y;
    logic              w_cur_v;
    logic              w_first, w_fwd;
    logic [X_W+1:0]    w_px;
    logic [Y_W+1:0]    w_py;
    logic              w_pix_we_nxt;
    logic [ADDR_W-1:0] w_pix_addr_nxt;
    logic              r_pix_we;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [7:0]        r_overrun;
`ifdef BOID_VALID_MASK_EN
    logic [NUM_BOIDS-1:0] r_valid;
    logic                 r_snap_v;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and the slot the next cycle will show (dx fastest, then dy, then boid)
    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_slot_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.frame_start) w_state_nxt = CLEAR;
            end
            CLEAR: begin
                w_state_nxt = SCAN;
                w_b_nxt     = '0;
                w_dx_nxt    = 2'd0;
                w_dy_nxt    = 2'd0;
                w_slot_nxt  = 1'b1;
            end
            SCAN: begin
                if (r_b == LP_LAST_B && r_dx == LP_SPR_MAX && r_dy == LP_SPR_MAX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_slot_nxt = 1'b1;
                    if (r_dx != LP_SPR_MAX) begin
                        w_dx_nxt = r_dx + 2'd1;
                    end else begin
                        w_dx_nxt = 2'd0;
                        if (r_dy != LP_SPR_MAX) begin
                            w_dy_nxt = r_dy + 2'd1;
                        end else begin
                            w_dy_nxt = 2'd0;
                            w_b_nxt  = r_b + IDX_W'(1);
                        end
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pixel for the next slot; a boid's first slot snapshots the array, forwarding a
    // write sampled on the same edge so it is visible one cycle after it was issued
    always_comb begin
        w_first = (w_dx_nxt == 2'd0) && (w_dy_nxt == 2'd0);
        w_fwd   = bus.cpu_we && (bus.cpu_idx == w_b_nxt);
        if (w_first) begin
            w_cur_x = w_fwd ? bus.cpu_x : r_pos_x[w_b_nxt];
            w_cur_y = w_fwd ? bus.cpu_y : r_pos_y[w_b_nxt];
        end else begin
            w_cur_x = r_snap_x;
            w_cur_y = r_snap_y;
        end
`ifdef BOID_VALID_MASK_EN
        w_cur_v = w_first ? (w_fwd || r_valid[w_b_nxt]) : r_snap_v;
`else
        w_cur_v = 1'b1;
`endif
        w_px           = {2'b00, w_cur_x} + {{X_W{1'b0}}, w_dx_nxt};
        w_py           = {2'b00, w_cur_y} + {{Y_W{1'b0}}, w_dy_nxt};
        w_pix_we_nxt   = w_slot_nxt && w_cur_v && (w_px < LP_SW) && (w_py < LP_SH);
        w_pix_addr_nxt = ADDR_W'(w_py) * LP_SW_A + ADDR_W'(w_px);
    end

    // Scan counters, per-boid snapshot and registered pixel outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_b        <= '0;
            r_dx       <= 2'd0;
            r_dy       <= 2'd0;
            r_snap_x   <= '0;
            r_snap_y   <= '0;
            r_pix_we   <= 1'b0;
            r_pix_addr <= '0;
`ifdef BOID_VALID_MASK_EN
            r_snap_v   <= 1'b0;
`endif
        end else begin
            r_b        <= w_b_nxt;
            r_dx       <= w_dx_nxt;
            r_dy       <= w_dy_nxt;
            r_snap_x   <= w_cur_x;
            r_snap_y   <= w_cur_y;
            r_pix_we   <= w_pix_we_nxt;
            r_pix_addr <= w_pix_addr_nxt;
`ifdef BOID_VALID_MASK_EN
            r_snap_v   <= w_cur_v;
`endif
        end
    end

    // Position array, written by the CPU in any state
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BOIDS; i++) begin
                r_pos_x[i] <= '0;
                r_pos_y[i] <= '0;
            end
`ifdef BOID_VALID_MASK_EN
            r_valid <= '0;
`endif
        end else if (bus.cpu_we) begin
            r_pos_x[bus.cpu_idx] <= bus.cpu_x;
            r_pos_y[bus.cpu_idx] <= bus.cpu_y;
`ifdef BOID_VALID_MASK_EN
            r_valid[bus.cpu_idx] <= 1'b1;
`endif
        end
    end

    // Saturating count of frame_start pulses dropped outside IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overrun <= 8'd0;
        end else if (bus.frame_start && r_state != IDLE && r_overrun != 8'hFF) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.clear       = (r_state == CLEAR);
    assign bus.done        = (r_state == DONE);
    assign bus.pix_we      = r_pix_we;
    assign bus.pix_addr    = r_pix_addr;
    assign bus.overrun_cnt = r_overrun;
endmodule

// File: tb/tb_boid_frame_renderer.sv
// Testbench for boid_frame_renderer: a cycle-level reference model of the pass
// timing and pixel rules runs alongside a SPRITE=1 instance; a SPRITE=2 instance
// covers sprite offsets and edge clipping with a hand-written sequence.
module tb_boid_frame_renderer;
    localparam int NB = 64;
    localparam int L1 = NB;
    localparam int L2 = NB * 4;
`ifdef BOID_VALID_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    typedef struct {
        int idx;
        int x;
        int y;
        bit we;
        int addr;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    boid_frame_renderer_if #(.IDX_W(6), .X_W(10), .Y_W(9), .ADDR_W(19)) bus1 ();
    boid_frame_renderer_if #(.IDX_W(6), .X_W(10), .Y_W(9), .ADDR_W(19)) bus2 ();

    boid_frame_renderer #(.NUM_BOIDS(NB), .SPRITE(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
    );
    boid_frame_renderer #(.NUM_BOIDS(NB), .SPRITE(2)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2)
    );

    // reference model state for dut1: positions, pass cycle number, overrun count
    int m_x [NB];
    int m_y [NB];
    bit m_v [NB];
    bit m_act = 1'b0;
    int m_t = 0;
    int m_ovr = 0;
    bit m_rst = 1'b0;
    int s_x = 0;
    int s_y = 0;
    bit s_v = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        bit e_slot;
        bit e_we;
        e_slot = m_act && m_t >= 2 && m_t <= L1 + 1;
        e_we   = e_slot && s_v && s_x < 640 && s_y < 480;
        chk("busy", 32'(bus1.busy), 32'(m_act && m_t >= 1 && m_t <= L1 + 2));
        chk("clear", 32'(bus1.clear), 32'(m_act && m_t == 1));
        chk("done", 32'(bus1.done), 32'(m_act && m_t == L1 + 2));
        chk("pix_we", 32'(bus1.pix_we), 32'(e_we));
        chk("overrun_cnt", 32'(bus1.overrun_cnt), m_ovr);
        if (e_we) chk("pix_addr", 32'(bus1.pix_addr), s_y * 640 + s_x);
        if (m_rst) chk("pix_addr_reset", 32'(bus1.pix_addr), 0);
    endtask

    // advance one clock, update the model with what was sampled, then check dut1
    task automatic tick();
        bit was_busy;
        int k;
        @(posedge clock);
        cyc++;
        if (reset) begin
            foreach (m_x[i]) begin
                m_x[i] = 0;
                m_y[i] = 0;
                m_v[i] = 1'b0;
            end
            m_act = 1'b0;
            m_t   = 0;
            m_ovr = 0;
            m_rst = 1'b1;
        end else begin
            m_rst = 1'b0;
            if (bus1.cpu_we) begin
                m_x[bus1.cpu_idx] = int'(bus1.cpu_x);
                m_y[bus1.cpu_idx] = int'(bus1.cpu_y);
                m_v[bus1.cpu_idx] = 1'b1;
            end
            was_busy = m_act && m_t >= 1 && m_t <= L1 + 2;
            if (m_act) m_t++;
            if (m_act && m_t > L1 + 2) m_act = 1'b0;
            if (bus1.frame_start) begin
                if (was_busy) begin
                    if (m_ovr < 255) m_ovr++;
                end else begin
                    m_act = 1'b1;
                    m_t   = 1;
                end
            end
            if (m_act && m_t >= 2 && m_t <= L1 + 1) begin
                k   = m_t - 2;
                s_x = m_x[k];
                s_y = m_y[k];
                s_v = m_v[k] || !MASK_EN;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic write1(input int idx, input int x, input int y);
        bus1.cpu_we  = 1'b1;
        bus1.cpu_idx = 6'(idx);
        bus1.cpu_x   = 10'(x);
        bus1.cpu_y   = 9'(y);
        tick();
        bus1.cpu_we  = 1'b0;
    endtask

    task automatic start1();
        bus1.frame_start = 1'b1;
        tick();
        bus1.frame_start = 1'b0;
    endtask

    initial begin
        vec_t vecs [7];
        int   s2_exp [4];
        int   n_we;
        int   n_done;
        int   n_nz;
        int   got_addr;
        bit   got_we;

        vecs[0] = '{3, 10, 2, 1'b1, 1290};
        vecs[1] = '{0, 0, 0, 1'b1, 0};
        vecs[2] = '{63, 639, 479, 1'b1, 307199};
        vecs[3] = '{7, 640, 5, 1'b0, 0};
        vecs[4] = '{9, 5, 480, 1'b0, 0};
        vecs[5] = '{1, 1023, 511, 1'b0, 0};
        vecs[6] = '{20, 100, 100, 1'b1, 64100};
        s2_exp  = '{6410, 6411, 7050, 7051};

        bus1.cpu_we = 1'b0; bus1.cpu_idx = '0; bus1.cpu_x = '0; bus1.cpu_y = '0;
        bus1.frame_start = 1'b0;
        bus2.cpu_we = 1'b0; bus2.cpu_idx = '0; bus2.cpu_x = '0; bus2.cpu_y = '0;
        bus2.frame_start = 1'b0;

        // reset state
        do_reset();

        // single-boid passes
        foreach (vecs[v]) begin
            do_reset();
            write1(vecs[v].idx, vecs[v].x, vecs[v].y);
            start1();
            n_we = 0; got_we = 1'b0; got_addr = 0;
            for (int c = 1; c <= L1 + 2; c++) begin
                if (bus1.pix_we) n_we++;
                if (c == 2 + vecs[v].idx) begin
                    got_we   = bus1.pix_we;
                    got_addr = int'(bus1.pix_addr);
                end
                if (c == L1 + 2) chk("tbl_done_cycle", 32'(bus1.done), 1);
                tick();
            end
            chk("tbl_slot_we", 32'(got_we), 32'(vecs[v].we));
            if (vecs[v].we) chk("tbl_slot_addr", got_addr, vecs[v].addr);
            chk("tbl_we_count", n_we, int'(vecs[v].we) + (MASK_EN ? 0 : NB - 1));
        end

        // dropped frame_starts mid-pass and in the done cycle; next idle cycle accepted
        do_reset();
        start1();
        n_done = 0;
        for (int c = 1; c <= L1 + 4; c++) begin
            if (bus1.done) n_done++;
            if (c == L1 + 4) chk("ovr_restart_clear", 32'(bus1.clear), 1);
            bus1.frame_start = (c == 10 || c == 20 || c == L1 + 2 || c == L1 + 3);
            tick();
        end
        bus1.frame_start = 1'b0;
        chk("ovr_count", 32'(bus1.overrun_cnt), 3);
        chk("ovr_done_pulses", n_done, 1);
        for (int i = 0; i < L1 + 4; i++) tick();

        // write landing in a boid's first slot is not used; one cycle earlier it is
        do_reset();
        write1(5, 200, 50);
        write1(9, 1, 1);
        start1();
        for (int c = 1; c <= L1 + 2; c++) begin
            if (c == 7) begin
                chk("race_old_we", 32'(bus1.pix_we), 1);
                chk("race_old_addr", 32'(bus1.pix_addr), 32200);
                bus1.cpu_we = 1'b1; bus1.cpu_idx = 6'd5; bus1.cpu_x = 10'd100; bus1.cpu_y = 9'd100;
            end
            if (c == 10) begin
                bus1.cpu_we = 1'b1; bus1.cpu_idx = 6'd9; bus1.cpu_x = 10'd7; bus1.cpu_y = 9'd3;
            end
            if (c == 11) chk("fwd_new_addr", 32'(bus1.pix_addr), 1927);
            tick();
            bus1.cpu_we = 1'b0;
        end
        tick();
        start1();
        for (int c = 1; c <= L1 + 2; c++) begin
            if (c == 7) chk("race_next_pass_addr", 32'(bus1.pix_addr), 64100);
            tick();
        end

        // reset in the middle of SCAN abandons the pass
        do_reset();
        write1(4, 30, 30);
        start1();
        for (int c = 1; c <= 30; c++) tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", 32'(bus1.busy), 0);
        chk("midrst_pix_we", 32'(bus1.pix_we), 0);
        chk("midrst_done", 32'(bus1.done), 0);
        chk("midrst_addr", 32'(bus1.pix_addr), 0);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus1.done) n_done++;
        end
        chk("midrst_no_done", n_done, 0);
        start1();
        n_we = 0; n_nz = 0;
        for (int c = 1; c <= L1 + 2; c++) begin
            if (bus1.pix_we) n_we++;
            if (bus1.pix_we && bus1.pix_addr != 19'd0) n_nz++;
            tick();
        end
        chk("midrst_we_count", n_we, MASK_EN ? 0 : NB);
        chk("midrst_nonzero_addr", n_nz, 0);

        // overrun counter saturates
        do_reset();
        bus1.frame_start = 1'b1;
        for (int i = 0; i < 420; i++) tick();
        bus1.frame_start = 1'b0;
        chk("ovr_saturate", 32'(bus1.overrun_cnt), 255);

        // randomized traffic against the model, with one reset in the middle
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus1.cpu_we  = ($urandom_range(0, 2) == 0);
            bus1.cpu_idx = 6'($urandom_range(0, 63));
            bus1.cpu_x   = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(600, 660))
                                                        : 10'($urandom_range(0, 1023));
            bus1.cpu_y   = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(450, 500))
                                                        : 9'($urandom_range(0, 511));
            bus1.frame_start = ($urandom_range(0, 39) == 0);
            reset = (i == 1500);
            tick();
        end
        reset = 1'b0;
        bus1.cpu_we = 1'b0;
        bus1.frame_start = 1'b0;

        // SPRITE=2: corner boid clipped to one pixel, slot order dx then dy
        do_reset();
        bus2.cpu_we = 1'b1; bus2.cpu_idx = 6'd0; bus2.cpu_x = 10'd639; bus2.cpu_y = 9'd479;
        tick();
        bus2.cpu_idx = 6'd1; bus2.cpu_x = 10'd10; bus2.cpu_y = 9'd10;
        tick();
        bus2.cpu_we = 1'b0;
        bus2.frame_start = 1'b1;
        tick();
        bus2.frame_start = 1'b0;
        n_we = 0;
        for (int c = 1; c <= L2 + 2; c++) begin
            if (bus2.pix_we) n_we++;
            if (c == 1) chk("s2_clear", 32'(bus2.clear), 1);
            if (c == 2) begin
                chk("s2_corner_we", 32'(bus2.pix_we), 1);
                chk("s2_corner_addr", 32'(bus2.pix_addr), 307199);
            end
            if (c >= 3 && c <= 5) chk("s2_clipped_we", 32'(bus2.pix_we), 0);
            if (c >= 6 && c <= 9) begin
                chk("s2_order_we", 32'(bus2.pix_we), 1);
                chk("s2_order_addr", 32'(bus2.pix_addr), s2_exp[c - 6]);
            end
            if (c == L2 + 2) chk("s2_done_cycle", 32'(bus2.done), 1);
            tick();
        end
        chk("s2_idle_after", 32'(bus2.busy), 0);
        chk("s2_we_count", n_we, 5 + (MASK_EN ? 0 : (NB - 2) * 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
